// File: rtl/apbmst_pkg.sv
// Shared definitions for the APB requester: FSM state encodings and the default wait limit.
package apbmst_pkg;

    typedef enum logic [1:0] {
        P_IDLE   = 2'h0,
        P_SETUP  = 2'h1,
        P_ACCESS = 2'h2
    } apbm_state_e;

    localparam int C_TIMEOUT_DEF = 16;

endpackage

// File: rtl/apbmst_tmr.sv
// ACCESS-phase wait counter: cleared on entry, counts PREADY-low cycles, flags the last allowed one.
module apbmst_tmr
    import apbmst_pkg::*;
#(
    parameter int P_TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    localparam int              C_W     = $clog2(P_TIMEOUT);
    localparam logic [C_W-1:0]  C_LIMIT = C_W'(P_TIMEOUT - 1);

    logic [C_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_hit = (r_cnt == C_LIMIT);

endmodule

// File: rtl/apbmst.sv
// APB requester: accepts one command at a time, runs SETUP/ACCESS, reports completion or timeout.
module apbmst
    import apbmst_pkg::*;
#(
    parameter int P_TIMEOUT = C_TIMEOUT_DEF
) (
    input  logic        I_APBM_PCLK,
    input  logic        I_APBM_PRESET_N,
    input  logic        I_APBM_REQ_VALID,
    output logic        O_APBM_REQ_READY,
    input  logic        I_APBM_REQ_WRITE,
    input  logic [31:0] I_APBM_REQ_ADDR,
    input  logic [31:0] I_APBM_REQ_WDATA,
    output logic        O_APBM_RSP_VALID,
    output logic [31:0] O_APBM_RSP_RDATA,
    output logic        O_APBM_RSP_TIMEOUT,
    output logic        O_APBM_PSEL,
    output logic        O_APBM_PENABLE,
    output logic        O_APBM_PWRITE,
    output logic [31:0] O_APBM_PADDR,
    output logic [31:0] O_APBM_PWDATA,
    input  logic [31:0] I_APBM_PRDATA,
    input  logic        I_APBM_PREADY
);

    apbm_state_e r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_rsp_timeout;
    logic [31:0] r_rsp_rdata;
    logic        r_psel;
    logic        r_penable;
    logic        r_pwrite;
    logic [31:0] r_paddr;
    logic [31:0] r_pwdata;

    logic w_tmr_clr;
    logic w_tmr_inc;
    logic w_tmr_hit;

    assign w_tmr_clr = (r_state == P_SETUP);
    assign w_tmr_inc = (r_state == P_ACCESS) && !I_APBM_PREADY;

    apbmst_tmr #(.P_TIMEOUT(P_TIMEOUT)) u_tmr (
        .i_clk   (I_APBM_PCLK),
        .i_rst_n (I_APBM_PRESET_N),
        .i_clr   (w_tmr_clr),
        .i_inc   (w_tmr_inc),
        .o_hit   (w_tmr_hit)
    );

    always_ff @(posedge I_APBM_PCLK or negedge I_APBM_PRESET_N) begin
        if (!I_APBM_PRESET_N) begin
            r_state       <= P_IDLE;
            r_req_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_rdata   <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
        end else begin
            // Response flags are single-cycle pulses; only the completing branch raises them.
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            case (r_state)
                P_IDLE: begin
                    if (r_req_ready && I_APBM_REQ_VALID) begin
                        r_req_ready <= 1'b0;
                        r_pwrite    <= I_APBM_REQ_WRITE;
                        r_paddr     <= I_APBM_REQ_ADDR;
                        r_pwdata    <= I_APBM_REQ_WDATA;
                        r_psel      <= 1'b1;
                        r_state     <= P_SETUP;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                P_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= P_ACCESS;
                end
                P_ACCESS: begin
                    // A ready completer in the limit cycle takes priority over the abort.
                    if (I_APBM_PREADY) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= P_IDLE;
                        if (!r_pwrite) begin
                            r_rsp_rdata <= I_APBM_PRDATA;
                        end
                    end else if (w_tmr_hit) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_req_ready   <= 1'b1;
                        r_state       <= P_IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= P_IDLE;
                end
            endcase
        end
    end

    assign O_APBM_REQ_READY   = r_req_ready;
    assign O_APBM_RSP_VALID   = r_rsp_valid;
    assign O_APBM_RSP_TIMEOUT = r_rsp_timeout;
    assign O_APBM_RSP_RDATA   = r_rsp_rdata;
    assign O_APBM_PSEL        = r_psel;
    assign O_APBM_PENABLE     = r_penable;
    assign O_APBM_PWRITE      = r_pwrite;
    assign O_APBM_PADDR       = r_paddr;
    assign O_APBM_PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apbmst.sv
// Directed bench for apbmst with a 4-cycle wait limit: table-driven transfers plus hand-written corner sequences.
module tb_apbmst;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;

    int total;
    int bad;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [7];

    apbmst #(.P_TIMEOUT(4)) dut (
        .I_APBM_PCLK        (clk),
        .I_APBM_PRESET_N    (rst_n),
        .I_APBM_REQ_VALID   (req_valid),
        .O_APBM_REQ_READY   (req_ready),
        .I_APBM_REQ_WRITE   (req_write),
        .I_APBM_REQ_ADDR    (req_addr),
        .I_APBM_REQ_WDATA   (req_wdata),
        .O_APBM_RSP_VALID   (rsp_valid),
        .O_APBM_RSP_RDATA   (rsp_rdata),
        .O_APBM_RSP_TIMEOUT (rsp_timeout),
        .O_APBM_PSEL        (psel),
        .O_APBM_PENABLE     (penable),
        .O_APBM_PWRITE      (pwrite),
        .O_APBM_PADDR       (paddr),
        .O_APBM_PWDATA      (pwdata),
        .I_APBM_PRDATA      (prdata),
        .I_APBM_PREADY      (pready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic budget_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait budget expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},   req_ready,   32'h0);
        check({tag, " rsp_valid"},   rsp_valid,   32'h0);
        check({tag, " rsp_rdata"},   rsp_rdata,   32'h0);
        check({tag, " rsp_timeout"}, rsp_timeout, 32'h0);
        check({tag, " psel"},        psel,        32'h0);
        check({tag, " penable"},     penable,     32'h0);
        check({tag, " pwrite"},      pwrite,      32'h0);
        check({tag, " paddr"},       paddr,       32'h0);
        check({tag, " pwdata"},      pwdata,      32'h0);
    endtask

    // One complete transfer; the completer raises PREADY in ACCESS cycle index v.waits.
    task automatic do_txn(input string tag, input vec_t v);
        int  n;
        int  k;
        bit  done;
        int  exp_acc;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            budget_fail({tag, " ready"});
            return;
        end
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        tick();
        req_valid = 1'b0;
        check({tag, " setup psel"},    psel,      32'h1);
        check({tag, " setup penable"}, penable,   32'h0);
        check({tag, " setup paddr"},   paddr,     v.addr);
        check({tag, " setup pwrite"},  pwrite,    {31'h0, v.wr});
        check({tag, " setup pwdata"},  pwdata,    v.wdata);
        check({tag, " setup ready"},   req_ready, 32'h0);
        tick();
        k    = 0;
        done = 1'b0;
        while (!done && k < 300) begin
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                check({tag, " access psel"},    psel,    32'h1);
                check({tag, " access penable"}, penable, 32'h1);
                check({tag, " access paddr"},   paddr,   v.addr);
                pready = (k == v.waits);
                prdata = v.prdata;
                tick();
                k++;
            end
        end
        pready = 1'b0;
        if (!done) begin
            budget_fail({tag, " rsp_valid"});
            return;
        end
        exp_acc = v.exp_to ? 4 : v.waits + 1;
        check({tag, " access cycles"}, k,           exp_acc);
        check({tag, " rsp_timeout"},   rsp_timeout, {31'h0, v.exp_to});
        check({tag, " rsp_rdata"},     rsp_rdata,   v.exp_rdata);
        check({tag, " done psel"},     psel,        32'h0);
        check({tag, " done penable"},  penable,     32'h0);
        check({tag, " done ready"},    req_ready,   32'h1);
        tick();
        check({tag, " pulse end"},     rsp_valid,   32'h0);
        check({tag, " timeout low"},   rsp_timeout, 32'h0);
        check({tag, " idle paddr"},    paddr,       v.addr);
        check({tag, " idle pwdata"},   pwdata,      v.wdata);
    endtask

    initial begin
        vec_t post;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b0;

        //          wr    addr           wdata          waits prdata         to    exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0020, 32'h0000_0040, 0,  32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1,  32'h0000_01E0, 1'b0, 32'h0000_01E0};
        vecs[2] = '{1'b0, 32'h0000_0013, 32'h0000_0000, 3,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 32'h0000_0014, 32'h0000_0000, 99, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 32'h7FFF_FFFE, 32'hA5A5_A5A5, 2,  32'hFFFF_FFFF, 1'b0, 32'hDEAD_BEEF};
        vecs[5] = '{1'b1, 32'h0000_0008, 32'h1111_2222, 99, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
        vecs[6] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 0,  32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D};

        // Reset state, then READY rises on the first edge after release.
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        check("release ready", req_ready, 32'h0);
        tick();
        check("first edge ready", req_ready, 32'h1);

        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("v%0d", i), vecs[i]);
        end

        // Held REQ_VALID with two commands: second accepted only in the first's RSP_VALID cycle.
        pready    = 1'b1;
        prdata    = 32'h0000_0077;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0100;
        req_wdata = 32'h0000_0011;
        tick();
        check("b2b A setup psel", psel, 32'h1);
        check("b2b A setup paddr", paddr, 32'h0000_0100);
        req_write = 1'b0;
        req_addr  = 32'h0000_0200;
        tick();
        check("b2b A access penable", penable, 32'h1);
        check("b2b A access paddr", paddr, 32'h0000_0100);
        check("b2b A access pwrite", pwrite, 32'h1);
        check("b2b A access ready", req_ready, 32'h0);
        tick();
        check("b2b A rsp_valid", rsp_valid, 32'h1);
        check("b2b A rsp_timeout", rsp_timeout, 32'h0);
        check("b2b A rdata kept", rsp_rdata, 32'h0BAD_F00D);
        check("b2b A psel dropped", psel, 32'h0);
        check("b2b A ready", req_ready, 32'h1);
        tick();
        req_valid = 1'b0;
        check("b2b B setup psel", psel, 32'h1);
        check("b2b B setup penable", penable, 32'h0);
        check("b2b B setup paddr", paddr, 32'h0000_0200);
        check("b2b B setup pwrite", pwrite, 32'h0);
        check("b2b B no pulse", rsp_valid, 32'h0);
        tick();
        check("b2b B access penable", penable, 32'h1);
        tick();
        pready = 1'b0;
        check("b2b B rsp_valid", rsp_valid, 32'h1);
        check("b2b B rdata", rsp_rdata, 32'h0000_0077);
        tick();

        // Reset asserted mid-ACCESS drops the transfer without a response.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0030;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("rst pre psel", psel, 32'h1);
        check("rst pre penable", penable, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async rst");
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst hold%0d rsp_valid", i), rsp_valid, 32'h0);
            check($sformatf("rst hold%0d psel", i), psel, 32'h0);
        end
        rst_n = 1'b1;
        tick();
        check("post rst ready", req_ready, 32'h1);
        check("post rst rsp_valid", rsp_valid, 32'h0);
        post = '{1'b0, 32'h0000_0034, 32'h0000_0000, 0, 32'h0000_0055, 1'b0, 32'h0000_0055};
        do_txn("post rst", post);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
